// File: rtl/cga_dbl_pkg.sv
// cga_dbl_pkg: sequencer state encoding and default timing constants for the CGA line doubler
package cga_dbl_pkg;
  typedef enum logic [1:0] {HUNT = 2'd0, LOCKED = 2'd1, COAST = 2'd2} dbl_state_t;
  localparam int DBL_LINE_CLKS = 1824;
  localparam int DBL_HALF_CLKS = 912;
  localparam int DBL_PULSE_W = 2;
endpackage

// File: rtl/cga_dbl_period_chk.sv
// cga_dbl_period_chk: line position counter, period capture and tolerance compare
//   clk, reset_n : clock, async active-low reset
//   clear        : restart pos at 0 on the next cycle
//   capture      : latch the current pos as the measured line period
//   pos          : 11-bit saturating position within the input line
//   in_tol       : last captured period lies within LINE_CLKS +/- LINE_TOL
module cga_dbl_period_chk
  import cga_dbl_pkg::*;
#(
  parameter int LINE_CLKS = DBL_LINE_CLKS,
  parameter int LINE_TOL = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        capture,
  output logic [10:0] pos,
  output logic        in_tol
);
  logic [10:0] period;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      pos <= '0;
      period <= '0;
    end else begin
      pos <= clear ? 11'd0 : pos + 11'(pos != 11'h7ff);
      if (capture) period <= pos;
    end
  assign in_tol = {1'b0, period} + 12'(LINE_TOL) >= 12'(LINE_CLKS) && period <= 11'(LINE_CLKS + LINE_TOL);
endmodule

// File: rtl/cga_dbl_sequencer.sv
// cga_dbl_sequencer: CRTC-to-line-doubler timing sequencer with flywheel
//   clk, reset_n         : 28.6364 MHz clock, async active-low reset
//   hsync/vsync/vblank_in: raw CRTC timing, active high
//   line_reset           : 2-cycle line start strobe to the line-store buffer
//   dbl_vsync, dbl_blank : vertical sync and blanking for the doubled output
//   dbl_phase            : 0 first repeat, 1 second repeat of the input line
//   locked               : sequencer is in LOCKED
//   dbl_scanline         : second-repeat dim flag, built only with CGA_DBL_SCANLINE_EN
module cga_dbl_sequencer
  import cga_dbl_pkg::*;
#(
  parameter int LINE_CLKS = DBL_LINE_CLKS,
  parameter int LINE_TOL = 16,
  parameter int LOCK_LINES = 4,
  parameter int MAX_COAST = 8,
  parameter int DBL_ACTIVE = 640,
  parameter int VID_LAT = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic hsync_in,
  input  logic vsync_in,
  input  logic vblank_in,
  output logic line_reset,
  output logic dbl_vsync,
  output logic dbl_blank,
  output logic dbl_phase,
  output logic locked,
  output logic dbl_scanline
);
  localparam int HALF = LINE_CLKS == DBL_LINE_CLKS ? DBL_HALF_CLKS : LINE_CLKS / 2;
  logic hsync_q, edge_q, issue_r, vsync_l, vblank_l, in_tol, timeout, coast_tick, issue, hsync_edge, blank_raw;
  logic [1:0] lr_cnt;
  logic [7:0] good_cnt, coast_cnt;
  logic [10:0] pos, pos_m;
  logic [VID_LAT-1:0] blank_d;
  dbl_state_t state;
  cga_dbl_period_chk #(.LINE_CLKS(LINE_CLKS), .LINE_TOL(LINE_TOL)) u_chk (
    .clk(clk),
    .reset_n(reset_n),
    .clear(issue),
    .capture(hsync_edge),
    .pos(pos),
    .in_tol(in_tol)
  );
  assign hsync_edge = hsync_in & ~hsync_q;
  // an edge always wins over a flywheel issue on the same cycle
  assign timeout = state == LOCKED && !hsync_edge && pos == 11'(LINE_CLKS + LINE_TOL);
  assign coast_tick = state == COAST && !hsync_edge && pos == 11'(LINE_CLKS - 1);
  assign issue = hsync_edge | timeout | coast_tick;
  assign line_reset = lr_cnt != 2'd0;
  assign dbl_vsync = vsync_l;
  assign locked = state == LOCKED;
  assign dbl_phase = pos >= 11'(HALF);
  assign pos_m = pos >= 11'(LINE_CLKS) ? pos - 11'(LINE_CLKS) : dbl_phase ? pos - 11'(HALF) : pos;
  assign blank_raw = pos_m >= 11'(DBL_ACTIVE) || vblank_l || state == HUNT;
  assign dbl_blank = blank_d[VID_LAT-1];
  // tolerance of an edge's period is judged one cycle later (edge_q), once it has been captured
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      hsync_q <= 1'b0;
      edge_q <= 1'b0;
      issue_r <= 1'b0;
      lr_cnt <= '0;
      vsync_l <= 1'b0;
      vblank_l <= 1'b0;
      good_cnt <= '0;
      coast_cnt <= '0;
      state <= HUNT;
      blank_d <= '1;
    end else begin
      hsync_q <= hsync_in;
      edge_q <= hsync_edge;
      issue_r <= issue;
      lr_cnt <= issue_r ? 2'(DBL_PULSE_W) : lr_cnt != 2'd0 ? lr_cnt - 2'd1 : 2'd0;
      if (issue) vblank_l <= vblank_in;
      if (issue_r) vsync_l <= vsync_in;
      blank_d <= VID_LAT'({blank_d, blank_raw});
      case (state)
        HUNT:
          if (edge_q) begin
            if (!in_tol) good_cnt <= '0;
            else if (good_cnt == 8'(LOCK_LINES - 1)) begin
              good_cnt <= '0;
              state <= LOCKED;
            end else good_cnt <= good_cnt + 8'd1;
          end
        LOCKED:
          if (edge_q && !in_tol) begin
            good_cnt <= '0;
            state <= HUNT;
          end else if (timeout) begin
            coast_cnt <= 8'd1;
            state <= COAST;
          end
        COAST:
          if (edge_q || coast_cnt == 8'(MAX_COAST)) begin
            coast_cnt <= '0;
            good_cnt <= '0;
            state <= HUNT;
          end else if (coast_tick) coast_cnt <= coast_cnt + 8'd1;
        default: state <= HUNT;
      endcase
    end
`ifdef CGA_DBL_SCANLINE_EN
  logic [VID_LAT-1:0] sl_d;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) sl_d <= '0;
    else sl_d <= VID_LAT'({sl_d, dbl_phase & ~blank_raw});
  assign dbl_scanline = sl_d[VID_LAT-1];
`else
  assign dbl_scanline = 1'b0;
`endif
endmodule

// File: tb/tb_cga_dbl_sequencer.sv
// tb_cga_dbl_sequencer: directed bench for the CGA line-doubler sequencer
module tb_cga_dbl_sequencer;
  logic clk = 1'b0, reset_n = 1'b0, hsync_in = 1'b0, vsync_in = 1'b0, vblank_in = 1'b0;
  logic line_reset, dbl_vsync, dbl_blank, dbl_phase, locked, dbl_scanline;
  int checks = 0, errors = 0, cyc = 0, last_d = 0;
  int lr_rise_cyc = 0, lr_rises = 0, lr_run = 0, lr_w = 0, vs_rise_cyc = 0, vs_fall_cyc = 0;
  logic lr_prev = 1'b0, vs_prev = 1'b0;
`ifdef CGA_DBL_SCANLINE_EN
  localparam bit SL = 1'b1;
`else
  localparam bit SL = 1'b0;
`endif
  cga_dbl_sequencer dut (
    .clk(clk),
    .reset_n(reset_n),
    .hsync_in(hsync_in),
    .vsync_in(vsync_in),
    .vblank_in(vblank_in),
    .line_reset(line_reset),
    .dbl_vsync(dbl_vsync),
    .dbl_blank(dbl_blank),
    .dbl_phase(dbl_phase),
    .locked(locked),
    .dbl_scanline(dbl_scanline)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    lr_prev <= line_reset;
    vs_prev <= dbl_vsync;
    lr_run <= line_reset ? lr_run + 1 : 0;
    if (line_reset && !lr_prev) begin
      lr_rise_cyc <= cyc;
      lr_rises <= lr_rises + 1;
    end
    if (!line_reset && lr_prev) lr_w <= lr_run;
    if (dbl_vsync && !vs_prev) vs_rise_cyc <= cyc;
    if (!dbl_vsync && vs_prev) vs_fall_cyc <= cyc;
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask
  // one input line of len clocks, starting at a negedge; c counts clocks from the first line_reset cycle
  task automatic line(input int len, input bit hs, input bit probe = 1'b0, input int vs_k = -1, input bit vs_v = 1'b0);
    int d, c;
    d = cyc;
    hsync_in = hs;
    for (int k = 0; k < len; k++) begin
      if (k == (len > 64 ? 64 : 1)) hsync_in = 1'b0;
      if (k == vs_k) vsync_in = vs_v;
      c = k - 2;
      if (probe) begin
        if (c == 0 || c == 641 || c == 912 || c == 1553) check("blank_hi", dbl_blank, 1);
        if (c == 1 || c == 640 || c == 913 || c == 1552) check("blank_lo", dbl_blank, 0);
        if (c == 910 || c == 911) check("phase", dbl_phase, c == 911);
        if (c == 500 || c == 912 || c == 913 || c == 1552 || c == 1553)
          check("scanline", dbl_scanline, SL && c >= 913 && c <= 1552);
      end
      @(negedge clk);
    end
    last_d = d;
  endtask
  initial begin
    int dl, n0, vb;
    repeat (3) @(negedge clk);
    check("rst_lr", line_reset, 0);
    check("rst_vsync", dbl_vsync, 0);
    check("rst_blank", dbl_blank, 1);
    check("rst_phase", dbl_phase, 0);
    check("rst_locked", locked, 0);
    check("rst_scan", dbl_scanline, 0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);
    line(1824, 1);
    check("lr_start", lr_rise_cyc, last_d + 2);
    check("lr_width", lr_w, 2);
    repeat (3) line(1824, 1);
    check("lock_4", locked, 0);
    line(1824, 1);
    check("lock_5", locked, 1);
    check("lr_count", lr_rises, 5);
    line(1824, 1, 1);
    line(1824, 1, 0, 900, 1);
    line(1824, 1);
    check("vs_rise", vs_rise_cyc, lr_rise_cyc);
    vb = vs_rise_cyc;
    line(1824, 1);
    line(1824, 1, 0, 900, 0);
    line(1824, 1);
    check("vs_fall", vs_fall_cyc, lr_rise_cyc);
    check("vs_len", vs_fall_cyc - vb, 3 * 1824);
    vblank_in = 1'b1;
    line(200, 1);
    check("vblank_on", dbl_blank, 1);
    vblank_in = 1'b0;
    line(1624, 0);
    line(200, 1);
    check("vblank_off", dbl_blank, 0);
    dl = last_d;
    line(1624, 0);
    n0 = lr_rises;
    line(100, 0);
    check("coast_first", lr_rise_cyc, dl + 1843);
    check("coast_active", dbl_blank, 0);
    check("coast_unlock", locked, 0);
    line(9 * 1824, 0);
    check("coast_count", lr_rises - n0, 8);
    check("coast_last", lr_rise_cyc, dl + 1843 + 7 * 1824);
    check("hunt_locked", locked, 0);
    check("hunt_blank", dbl_blank, 1);
    line(2, 1);
    line(1824, 1);
    check("lr_restart", lr_w, 4);
    repeat (4) line(1824, 1);
    check("relock_a", locked, 1);
    line(1700, 1);
    line(1824, 1);
    check("short_lr", lr_rise_cyc, last_d + 2);
    check("short_unlock", locked, 0);
    repeat (3) line(1824, 1);
    check("relock_b3", locked, 0);
    line(1824, 1);
    check("relock_b4", locked, 1);
    line(1000, 1);
    check("mid_phase", dbl_phase, 1);
    check("mid_blank", dbl_blank, 0);
    reset_n = 1'b0;
    #1;
    check("arst_locked", locked, 0);
    check("arst_blank", dbl_blank, 1);
    check("arst_phase", dbl_phase, 0);
    check("arst_lr", line_reset, 0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    line(1824, 1);
    check("post_lr", lr_rise_cyc, last_d + 2);
    check("post_locked", locked, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
